// File: rtl/hci_core_stream_source.sv
// TCDM-to-stream read engine: issues strided word reads, buffers the responses in a
// small FIFO and replays them in order on a valid/ready stream.
module hci_core_stream_source #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   stride_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    ready_start_o,
  output logic                    done_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  input  logic                    tcdm_r_valid_i,
  output logic                    stream_valid_o,
  input  logic                    stream_ready_i,
  output logic [DATA_WIDTH-1:0]   stream_data_o,
  output logic [DATA_WIDTH/8-1:0] stream_strb_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_WIDTH  = CNT_WIDTH + 1;
  // Headroom for several clears landing while older reads are still outstanding.
  localparam int unsigned DROP_WIDTH = CNT_WIDTH + 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WORKING = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   stride_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    issued_q;
  logic [CNT_WIDTH-1:0]    inflight_q;
  logic [DROP_WIDTH-1:0]   drop_q;
  logic [DROP_WIDTH-1:0]   drop_on_clear;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]    wptr_q, rptr_q;
  logic [CNT_WIDTH-1:0]    count_q;

  logic [OCC_WIDTH-1:0]    occupancy;
  logic                    has_credit;
  logic                    req;
  logic                    grant;
  logic                    drop_active;
  logic                    push;
  logic                    pop;
  logic                    fifo_valid;

  // Credit covers both buffered words and reads whose data is still on the way.
  assign occupancy   = OCC_WIDTH'(count_q) + OCC_WIDTH'(inflight_q);
  assign has_credit  = occupancy < OCC_WIDTH'(FIFO_DEPTH);
  assign req         = (state_q == WORKING) && (issued_q < len_q) && has_credit;
  assign grant       = req && tcdm_gnt_i;
  assign drop_active = (drop_q != '0);
  assign fifo_valid  = (count_q != '0);
  assign push        = tcdm_r_valid_i && !drop_active && !clear_i;
  assign pop         = fifo_valid && stream_ready_i && !clear_i;

  assign ready_start_o  = (state_q == IDLE);
  assign done_o         = (state_q == DONE);
  assign tcdm_req_o     = req;
  assign tcdm_add_o     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign tcdm_wen_o     = req;
  assign tcdm_be_o      = {STRB_WIDTH{req}};
  assign tcdm_data_o    = '0;
  assign stream_valid_o = fifo_valid;
  assign stream_data_o  = fifo_valid ? fifo_mem[rptr_q] : '0;
  assign stream_strb_o  = {STRB_WIDTH{fifo_valid}};

  // Responses still owed to the bus after a clear, including one granted this cycle.
  always_comb begin
    drop_on_clear = drop_q + DROP_WIDTH'(inflight_q) + DROP_WIDTH'(grant);
    if (tcdm_r_valid_i && (drop_active || (inflight_q != '0))) begin
      drop_on_clear = drop_on_clear - DROP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : WORKING;
      WORKING: if (issued_q == len_q) state_d = DRAIN;
      DRAIN:   if ((inflight_q == '0) && !fifo_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
    end
  end

  // Transfer bookkeeping: address walk, issue/in-flight counters and the drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else if (clear_i) begin
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= '0;
      drop_q     <= drop_on_clear;
    end else begin
      if ((state_q == IDLE) && start_i) begin
        addr_q   <= base_addr_i;
        stride_q <= stride_i;
        len_q    <= len_i;
        issued_q <= '0;
      end else if (grant) begin
        addr_q   <= addr_q + stride_q;
        issued_q <= issued_q + LEN_WIDTH'(1);
      end
      if (grant && !push) begin
        inflight_q <= inflight_q + CNT_WIDTH'(1);
      end else if (!grant && push) begin
        inflight_q <= inflight_q - CNT_WIDTH'(1);
      end
      if (tcdm_r_valid_i && drop_active) begin
        drop_q <= drop_q - DROP_WIDTH'(1);
      end
    end
  end

  // Response FIFO pointers and fill level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_WIDTH'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_WIDTH'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wptr_q] <= tcdm_r_data_i;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(push && (count_q == CNT_WIDTH'(FIFO_DEPTH))));

endmodule
